// File: rtl/ins_cache_nway.sv
// ins_cache_nway: N-way set-associative instruction-cache tag store with true-LRU
// replacement, a registered command interface and a valid/ready line-fill request.
//
// Optional feature macro: INS_CACHE_STATS_EN
//   defined   -> hit_o/miss_o/reads_o are saturating 32-bit statistics counters
//   undefined -> no counter flops, the three outputs are tied to zero
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid_i       command present
//   cmd_ready_o       block can accept a command (IDLE only)
//   cmd_op_i          8=RESET, 3=INVALIDATE, 2=INST_FETCH, 9=PRINT, others ignored
//   cmd_addr_i        byte address
//   mem_req_valid_o   line-fill request to next level
//   mem_req_ready_i   next level accepts the request
//   mem_req_addr_o    line address {tag, index}
//   resp_valid_o      one-cycle completion pulse
//   resp_hit_o        fetch hit / invalidate found a match
//   hit_o/miss_o/reads_o  statistics counters
module ins_cache_nway #(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned INDEX_BITS  = 14,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [3:0]                    cmd_op_i,
  input  logic [ADDR_W-1:0]             cmd_addr_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_W-OFFSET_BITS-1:0] mem_req_addr_o,
  output logic                          resp_valid_o,
  output logic                          resp_hit_o,
  output logic [31:0]                   hit_o,
  output logic [31:0]                   miss_o,
  output logic [31:0]                   reads_o
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS  = 1 << INDEX_BITS;
  localparam int unsigned AGE_W = $clog2(WAYS);

  localparam logic [1:0] StFlush   = 2'd0;
  localparam logic [1:0] StIdle    = 2'd1;
  localparam logic [1:0] StLookup  = 2'd2;
  localparam logic [1:0] StMissReq = 2'd3;

  localparam logic [3:0] OpFetch = 4'd2;
  localparam logic [3:0] OpInval = 4'd3;
  localparam logic [3:0] OpReset = 4'd8;

  // Tag store; initialised by the flush sweep, so no reset is needed here.
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] flush_idx_q, flush_idx_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;

  logic [INDEX_BITS-1:0] cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit_any;
  logic [AGE_W-1:0]      hit_way, victim_way, acc_way, acc_age;
  logic                  inv_found;
  logic [AGE_W-1:0]      lru_row [WAYS];

  logic                  row_we, tag_we;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [WAYS-1:0]       valid_row_d;
  logic [AGE_W-1:0]      age_row_d [WAYS];

  logic accept;
  logic cnt_clr, cnt_read, cnt_hit, cnt_miss;

  assign cur_idx         = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign cur_tag         = addr_q[ADDR_W-1 -: TAG_W];
  assign cmd_ready_o     = (state_q == StIdle);
  assign accept          = cmd_valid_i && cmd_ready_o;
  assign mem_req_valid_o = (state_q == StMissReq);
  assign mem_req_addr_o  = addr_q[ADDR_W-1:OFFSET_BITS];
  assign resp_valid_o    = resp_valid_q;
  assign resp_hit_o      = resp_hit_q;

  logic unused_offset;
  assign unused_offset = ^addr_q[OFFSET_BITS-1:0];

  // Tag compare, victim choice and LRU row update for the registered set.
  always_comb begin
    hit_vec    = '0;
    hit_way    = '0;
    victim_way = '0;
    inv_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag);
      if (hit_vec[w]) hit_way = AGE_W'(w);
      if (!valid_q[cur_idx][w] && !inv_found) begin
        victim_way = AGE_W'(w);
        inv_found  = 1'b1;
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[cur_idx][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
      end
    end
    hit_any = |hit_vec;
    acc_way = (state_q == StLookup) ? hit_way : victim_way;
    acc_age = age_q[cur_idx][acc_way];
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way) begin
        lru_row[w] = '0;
      end else if (age_q[cur_idx][w] < acc_age) begin
        lru_row[w] = age_q[cur_idx][w] + AGE_W'(1);
      end else begin
        lru_row[w] = age_q[cur_idx][w];
      end
    end
  end

  // Row write-back selection.
  always_comb begin
    row_we      = 1'b0;
    tag_we      = 1'b0;
    wr_idx      = cur_idx;
    valid_row_d = valid_q[cur_idx];
    for (int w = 0; w < WAYS; w++) age_row_d[w] = age_q[cur_idx][w];
    unique case (state_q)
      StFlush: begin
        row_we      = 1'b1;
        wr_idx      = flush_idx_q;
        valid_row_d = '0;
        for (int w = 0; w < WAYS; w++) age_row_d[w] = AGE_W'(w);
      end
      StLookup: begin
        if (hit_any) begin
          row_we = 1'b1;
          if (op_q == OpInval) begin
            valid_row_d[hit_way] = 1'b0;
          end else begin
            for (int w = 0; w < WAYS; w++) age_row_d[w] = lru_row[w];
          end
        end
      end
      StMissReq: begin
        if (mem_req_ready_i) begin
          row_we                  = 1'b1;
          tag_we                  = 1'b1;
          valid_row_d[victim_way] = 1'b1;
          for (int w = 0; w < WAYS; w++) age_row_d[w] = lru_row[w];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (row_we) begin
      valid_q[wr_idx] <= valid_row_d;
      for (int w = 0; w < WAYS; w++) age_q[wr_idx][w] <= age_row_d[w];
    end
    if (tag_we) tag_q[cur_idx][victim_way] <= cur_tag;
  end

  // Control FSM next state.
  always_comb begin
    state_d      = state_q;
    flush_idx_d  = flush_idx_q;
    op_d         = op_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_read     = 1'b0;
    cnt_hit      = 1'b0;
    cnt_miss     = 1'b0;
    unique case (state_q)
      StFlush: begin
        flush_idx_d = flush_idx_q + INDEX_BITS'(1);
        if (&flush_idx_q) state_d = StIdle;
      end
      StIdle: begin
        if (accept) begin
          op_d   = cmd_op_i;
          addr_d = cmd_addr_i;
          if (cmd_op_i == OpFetch || cmd_op_i == OpInval) begin
            state_d = StLookup;
          end else if (cmd_op_i == OpReset) begin
            cnt_clr     = 1'b1;
            flush_idx_d = '0;
            state_d     = StFlush;
          end
        end
      end
      StLookup: begin
        state_d = StIdle;
        if (op_q == OpFetch) begin
          cnt_read = 1'b1;
          if (hit_any) begin
            cnt_hit      = 1'b1;
            resp_valid_d = 1'b1;
            resp_hit_d   = 1'b1;
          end else begin
            cnt_miss = 1'b1;
            state_d  = StMissReq;
          end
        end else begin
          resp_valid_d = 1'b1;
          resp_hit_d   = hit_any;
        end
      end
      StMissReq: begin
        if (mem_req_ready_i) begin
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StFlush;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFlush;
      flush_idx_q  <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
    end
  end

`ifdef INS_CACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d, reads_q, reads_d;

  // Saturating increments; a RESET op clears all three.
  always_comb begin
    hit_d   = hit_q;
    miss_d  = miss_q;
    reads_d = reads_q;
    if (cnt_clr) begin
      hit_d   = '0;
      miss_d  = '0;
      reads_d = '0;
    end else begin
      if (cnt_hit && !(&hit_q))     hit_d   = hit_q + 32'd1;
      if (cnt_miss && !(&miss_q))   miss_d  = miss_q + 32'd1;
      if (cnt_read && !(&reads_q))  reads_d = reads_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= '0;
      miss_q  <= '0;
      reads_q <= '0;
    end else begin
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      reads_q <= reads_d;
    end
  end

  assign hit_o   = hit_q;
  assign miss_o  = miss_q;
  assign reads_o = reads_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, cnt_read, cnt_hit, cnt_miss};
  assign hit_o      = 32'd0;
  assign miss_o     = 32'd0;
  assign reads_o    = 32'd0;
`endif

endmodule
